// File: rtl/apb_regfile_v2_if.sv
// APB4 completer-side bus bundle for apb_regfile_v2.
// The master drives the request and the slave returns the response.
interface apb_regfile_v2_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   paddr;
  logic            psel;
  logic            penable;
  logic            pwrite;
  logic [DW-1:0]   pwdata;
  logic [DW/8-1:0] pstrb;
  logic [DW-1:0]   prdata;
  logic            pready;
  logic            pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_regfile_v2.sv
// Parametrised APB4 register file with RW, read-only and W1C sticky registers.
// Supports byte strobes, fixed wait states and error responses on bad accesses.
module apb_regfile_v2 #(
  parameter int unsigned      DW          = 32,
  parameter int unsigned      AW          = 8,
  parameter int unsigned      NREGS       = 8,
  parameter int unsigned      WAIT_CYCLES = 0,
  parameter logic [NREGS-1:0] RO_MASK     = '0,
  parameter logic [NREGS-1:0] W1C_MASK    = '0
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_regfile_v2_if.slave       bus,
  output logic [NREGS*DW-1:0]   reg_out,
  input  logic [NREGS*DW-1:0]   hw_status,
  input  logic [NREGS*DW-1:0]   hw_set,
  output logic                  irq
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned IW = AW - 2;
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q;
  logic                write_q;
  logic [DW-1:0]       wdata_q;
  logic [NB-1:0]       strb_q;
  logic                err_q;
  logic [DW-1:0]       prdata_q;
  logic [NREGS*DW-1:0] regs_q, regs_d;
  logic                irq_q;

  logic                setup, done, commit;
  logic [IW-1:0]       idx;
  logic                in_range, ro_hit, err;
  logic [DW-1:0]       rd_val, bmask;
  logic [NREGS*DW-1:0] w1c_bits;

  assign idx    = bus.paddr[AW-1:2];
  assign setup  = bus.psel & ~bus.penable;
  assign done   = (state_q == StAccess) & (cnt_q == '0) & bus.psel & bus.penable;
  assign commit = done & write_q & ~err_q;
  assign irq    = irq_q;

  // Decode of the live address; only consumed when a setup phase is seen.
  always_comb begin
    in_range = 1'b0;
    ro_hit   = 1'b0;
    rd_val   = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (idx == IW'(i)) begin
        in_range = 1'b1;
        ro_hit   = RO_MASK[i];
        rd_val   = reg_out[i*DW +: DW];
      end
    end
    err = (bus.paddr[1:0] != 2'b00) | ~in_range | (bus.pwrite & ro_hit);
  end

  always_comb begin
    reg_out  = '0;
    w1c_bits = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      reg_out[i*DW +: DW]  = RO_MASK[i] ? hw_status[i*DW +: DW] : regs_q[i*DW +: DW];
      w1c_bits[i*DW +: DW] = (W1C_MASK[i] & ~RO_MASK[i]) ? regs_q[i*DW +: DW] : '0;
    end
  end

  always_comb begin
    bmask = '0;
    for (int unsigned k = 0; k < NB; k++) begin
      bmask[k*8 +: 8] = {8{strb_q[k]}};
    end
  end

  // W1C: hw_set is OR-ed in after the clear, so a coincident set wins.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (RO_MASK[i]) begin
        regs_d[i*DW +: DW] = '0;
      end else if (W1C_MASK[i]) begin
        regs_d[i*DW +: DW] = (regs_q[i*DW +: DW]
                             & ~(wdata_q & bmask & {DW{commit && (idx_q == IW'(i))}}))
                             | hw_set[i*DW +: DW];
      end else if (commit && (idx_q == IW'(i))) begin
        regs_d[i*DW +: DW] = (regs_q[i*DW +: DW] & ~bmask) | (wdata_q & bmask);
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      regs_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      irq_q   <= |w1c_bits;
      if ((state_q == StIdle) && setup) begin
        idx_q    <= idx;
        write_q  <= bus.pwrite;
        wdata_q  <= bus.pwdata;
        strb_q   <= bus.pstrb;
        err_q    <= err;
        prdata_q <= (err | bus.pwrite) ? '0 : rd_val;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          state_d = StAccess;
          cnt_d   = CW'(WAIT_CYCLES);
        end
      end
      StAccess: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        // Dropping psel mid-access aborts the transfer without a commit.
        if (!bus.psel || done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    if (state_q == StAccess) begin
      bus.pready  = (cnt_q == '0);
      bus.pslverr = (cnt_q == '0) & err_q;
      bus.prdata  = prdata_q;
    end
  end

  // RO slices of regs_q and hw_set bits of non-W1C registers are intentionally unread.
  logic unused_bits;
  assign unused_bits = ^{regs_q, hw_set, hw_status};

endmodule

// File: tb/tb_apb_regfile_v2.sv
// Directed bench for apb_regfile_v2: three instances cover zero-wait with RO/W1C
// registers, three wait states, and two wait states with reset asserted mid-access.
module tb_apb_regfile_v2;
  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  logic [7:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  psel_v;

  apb_regfile_v2_if #(.AW(8), .DW(32)) a_if ();
  apb_regfile_v2_if #(.AW(8), .DW(32)) b_if ();
  apb_regfile_v2_if #(.AW(8), .DW(32)) c_if ();

  assign a_if.paddr = paddr;  assign a_if.pwrite = pwrite;  assign a_if.penable = penable;
  assign a_if.pwdata = pwdata; assign a_if.pstrb = pstrb;   assign a_if.psel = psel_v[0];
  assign b_if.paddr = paddr;  assign b_if.pwrite = pwrite;  assign b_if.penable = penable;
  assign b_if.pwdata = pwdata; assign b_if.pstrb = pstrb;   assign b_if.psel = psel_v[1];
  assign c_if.paddr = paddr;  assign c_if.pwrite = pwrite;  assign c_if.penable = penable;
  assign c_if.pwdata = pwdata; assign c_if.pstrb = pstrb;   assign c_if.psel = psel_v[2];

  logic [255:0] reg_out_a, reg_out_b, reg_out_c;
  logic [255:0] hw_status_a, hw_set_a, zero_bus;
  logic         irq_a, irq_b, irq_c;
  assign zero_bus = '0;

  apb_regfile_v2 #(
    .DW(32), .AW(8), .NREGS(8), .WAIT_CYCLES(0), .RO_MASK(8'h04), .W1C_MASK(8'h02)
  ) u_dut_a (
    .pclk(pclk), .preset(preset), .bus(a_if.slave), .reg_out(reg_out_a),
    .hw_status(hw_status_a), .hw_set(hw_set_a), .irq(irq_a)
  );

  apb_regfile_v2 #(
    .DW(32), .AW(8), .NREGS(8), .WAIT_CYCLES(3), .RO_MASK(8'h00), .W1C_MASK(8'h00)
  ) u_dut_b (
    .pclk(pclk), .preset(preset), .bus(b_if.slave), .reg_out(reg_out_b),
    .hw_status(zero_bus), .hw_set(zero_bus), .irq(irq_b)
  );

  apb_regfile_v2 #(
    .DW(32), .AW(8), .NREGS(8), .WAIT_CYCLES(2), .RO_MASK(8'h00), .W1C_MASK(8'h00)
  ) u_dut_c (
    .pclk(pclk), .preset(preset), .bus(c_if.slave), .reg_out(reg_out_c),
    .hw_status(zero_bus), .hw_set(zero_bus), .irq(irq_c)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int s);
    case (s)
      0:       get_rdy = a_if.pready;
      1:       get_rdy = b_if.pready;
      default: get_rdy = c_if.pready;
    endcase
  endfunction

  function automatic logic get_err(input int s);
    case (s)
      0:       get_err = a_if.pslverr;
      1:       get_err = b_if.pslverr;
      default: get_err = c_if.pslverr;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int s);
    case (s)
      0:       get_rdata = a_if.prdata;
      1:       get_rdata = b_if.prdata;
      default: get_rdata = c_if.prdata;
    endcase
  endfunction

  // One APB transfer on instance s; returns data, error and number of wait cycles seen.
  task automatic xfer(input int s, input logic [7:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd, output logic err, output int waits);
    @(negedge pclk);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    psel_v = '0; psel_v[s] = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (!get_rdy(s) && waits < 20) begin
      @(negedge pclk);
      waits++;
    end
    check("pready_seen", get_rdy(s), 1'b1);
    rd  = get_rdata(s);
    err = get_err(s);
    @(negedge pclk);
    psel_v = '0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    preset = 1'b1; psel_v = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; hw_set_a = '0; hw_status_a = '0;
    hw_status_a[95:64] = 32'h5A5A_0000;
    repeat (3) @(negedge pclk);
    check("rst_pready",   a_if.pready,        1'b0);
    check("rst_pslverr",  a_if.pslverr,       1'b0);
    check("rst_prdata",   a_if.prdata,        32'h0);
    check("rst_irq",      irq_a,              1'b0);
    check("rst_reg1",     reg_out_a[63:32],   32'h0);
    check("rst_ro_slice", reg_out_a[95:64],   32'h5A5A_0000);
    preset = 1'b0;

    // Basic write/read, zero wait
    xfer(0, 8'h1C, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, err, w);
    check("wr1c_err", err, 1'b0);
    check("wr1c_waits", w, 0);
    xfer(0, 8'h1C, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("rd1c_data", rd, 32'hDEAD_BEEF);
    check("rd1c_err", err, 1'b0);
    check("rd1c_waits", w, 0);
    check("reg7_out", reg_out_a[255:224], 32'hDEAD_BEEF);

    // Byte strobes
    xfer(0, 8'h00, 1'b1, 32'h1122_3344, 4'hF, rd, err, w);
    xfer(0, 8'h00, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, err, w);
    check("strb_reg0", reg_out_a[31:0], 32'h11BB_33DD);
    xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("strb_rd0", rd, 32'h11BB_33DD);
    xfer(0, 8'h00, 1'b1, 32'hFFFF_FFFF, 4'h0, rd, err, w);
    check("strb0_err", err, 1'b0);
    check("strb0_reg0", reg_out_a[31:0], 32'h11BB_33DD);

    // Error responses
    xfer(0, 8'h20, 1'b1, 32'h1234_5678, 4'hF, rd, err, w);
    check("oob_wr_err", err, 1'b1);
    check("oob_wr_reg7", reg_out_a[255:224], 32'hDEAD_BEEF);
    xfer(0, 8'h02, 1'b1, 32'h1234_5678, 4'hF, rd, err, w);
    check("mis_wr_err", err, 1'b1);
    check("mis_wr_reg0", reg_out_a[31:0], 32'h11BB_33DD);
    xfer(0, 8'h08, 1'b1, 32'h1234_5678, 4'hF, rd, err, w);
    check("ro_wr_err", err, 1'b1);
    check("ro_wr_slice", reg_out_a[95:64], 32'h5A5A_0000);
    xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("ro_rd_data", rd, 32'h5A5A_0000);
    check("ro_rd_err", err, 1'b0);
    xfer(0, 8'h20, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("oob_rd_data", rd, 32'h0);
    check("oob_rd_err", err, 1'b1);
    xfer(0, 8'h1E, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("mis_rd_data", rd, 32'h0);
    check("mis_rd_err", err, 1'b1);

    // W1C and irq
    @(negedge pclk);
    hw_set_a[35] = 1'b1;
    @(negedge pclk);
    hw_set_a[35] = 1'b0;
    check("w1c_set_reg1", reg_out_a[63:32], 32'h8);
    check("w1c_irq_lag", irq_a, 1'b0);
    @(negedge pclk);
    check("w1c_irq_set", irq_a, 1'b1);
    hw_set_a[35] = 1'b1;
    xfer(0, 8'h04, 1'b1, 32'h8, 4'hF, rd, err, w);
    hw_set_a[35] = 1'b0;
    check("w1c_setwins_err", err, 1'b0);
    check("w1c_setwins_reg1", reg_out_a[63:32], 32'h8);
    check("w1c_setwins_irq", irq_a, 1'b1);
    xfer(0, 8'h04, 1'b1, 32'h8, 4'hF, rd, err, w);
    check("w1c_clr_reg1", reg_out_a[63:32], 32'h0);
    check("w1c_clr_irq_lag", irq_a, 1'b1);
    @(negedge pclk);
    check("w1c_clr_irq", irq_a, 1'b0);

    // Wait states (3)
    xfer(1, 8'h04, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("ws3_rd_waits", w, 3);
    check("ws3_rd_err", err, 1'b0);
    check("ws3_rd_data", rd, 32'h0);
    xfer(1, 8'h04, 1'b1, 32'h1234_5678, 4'hF, rd, err, w);
    check("ws3_wr_waits", w, 3);
    xfer(1, 8'h04, 1'b0, 32'h0, 4'h0, rd, err, w);
    check("ws3_rdback", rd, 32'h1234_5678);

    // Reset asserted during the access phase of a write (2 wait states)
    @(negedge pclk);
    paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    psel_v = 3'b100; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    check("mid_pready_before", c_if.pready, 1'b0);
    @(negedge pclk);
    preset = 1'b1;
    #1;
    check("mid_rst_pready", c_if.pready, 1'b0);
    check("mid_rst_pslverr", c_if.pslverr, 1'b0);
    check("mid_rst_reg3", reg_out_c[127:96], 32'h0);
    check("mid_rst_a_reg0", reg_out_a[31:0], 32'h0);
    repeat (2) @(negedge pclk);
    psel_v = '0; penable = 1'b0; preset = 1'b0;
    check("post_rst_reg3", reg_out_c[127:96], 32'h0);
    xfer(2, 8'h0C, 1'b1, 32'hCAFE_F00D, 4'hF, rd, err, w);
    check("post_rst_waits", w, 2);
    check("post_rst_err", err, 1'b0);
    check("post_rst_commit", reg_out_c[127:96], 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
